// File: rtl/fc2_result_scheduler.sv
// fc2_result_scheduler: sequences FC2 MAC passes per class, forwards scores to argmax, offers the result via valid/ready.
// Define FC2_BIAS_EN to add a per-class bias ROM port whose data is added to each score.
module fc2_result_scheduler #(
    parameter int NUM_CLASSES = 10,
    parameter int IN_LEN      = 84,
    parameter int ADDR_W      = 7,
    parameter int WADDR_W     = 10,
    parameter int MAC_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    output logic                o_busy,
    output logic [ADDR_W-1:0]   o_feat_addr,
    output logic [WADDR_W-1:0]  o_wgt_addr,
    output logic                o_mac_en,
    output logic                o_mac_clr,
    input  logic signed [31:0]  i_mac_acc,
    output logic signed [31:0]  o_score,
    output logic                o_score_en,
`ifdef FC2_BIAS_EN
    output logic [3:0]          o_bias_addr,
    input  logic signed [31:0]  i_bias_data,
`endif
    input  logic                i_argmax_valid,
    input  logic [3:0]          i_argmax_class,
    output logic [3:0]          o_result,
    output logic                o_result_valid,
    input  logic                i_result_ready
);
    localparam int CLS_W = 4;
    localparam int DRN_W = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, WAIT_AM, HOLD} state_t;

    state_t             r_state;
    logic [CLS_W-1:0]   r_cls;
    logic [DRN_W-1:0]   r_drn;
    logic signed [31:0] w_score;

`ifdef FC2_BIAS_EN
    // class counter is stable since RUN, so the 1-cycle ROM read has settled by the end of DRAIN
    assign o_bias_addr = r_cls;
    assign w_score     = i_mac_acc + i_bias_data;
`else
    assign w_score     = i_mac_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cls          <= '0;
            r_drn          <= '0;
            o_busy         <= 1'b0;
            o_feat_addr    <= '0;
            o_wgt_addr     <= '0;
            o_mac_en       <= 1'b0;
            o_mac_clr      <= 1'b0;
            o_score        <= '0;
            o_score_en     <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            o_score_en <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state     <= RUN;
                    o_busy      <= 1'b1;
                    r_cls       <= '0;
                    o_feat_addr <= '0;
                    o_wgt_addr  <= '0;
                    o_mac_en    <= 1'b1;
                    o_mac_clr   <= 1'b1;
                end
                RUN: begin
                    o_mac_clr <= 1'b0;
                    if (o_feat_addr == ADDR_W'(IN_LEN - 1)) begin
                        o_feat_addr <= '0;
                        o_mac_en    <= 1'b0;
                        r_state     <= DRAIN;
                    end else begin
                        o_feat_addr <= o_feat_addr + 1'b1;
                        o_wgt_addr  <= o_wgt_addr + 1'b1;
                    end
                end
                DRAIN: if (r_drn == DRN_W'(MAC_LAT - 1)) begin
                    r_drn      <= '0;
                    o_score    <= w_score;
                    o_score_en <= 1'b1;
                    r_state    <= EMIT;
                end else begin
                    r_drn <= r_drn + 1'b1;
                end
                // weight address advances here so it keeps running across classes without a multiply
                EMIT: if (r_cls == CLS_W'(NUM_CLASSES - 1)) begin
                    r_state <= WAIT_AM;
                end else begin
                    r_cls      <= r_cls + 1'b1;
                    o_wgt_addr <= o_wgt_addr + 1'b1;
                    o_mac_en   <= 1'b1;
                    o_mac_clr  <= 1'b1;
                    r_state    <= RUN;
                end
                WAIT_AM: if (i_argmax_valid) begin
                    o_result       <= i_argmax_class;
                    o_result_valid <= 1'b1;
                    r_state        <= HOLD;
                end
                HOLD: if (i_result_ready) begin
                    o_result_valid <= 1'b0;
                    o_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc2_result_scheduler.sv
// tb_fc2_result_scheduler: directed bench with behavioural MAC, argmax stage and bias ROM around the scheduler.
module tb_fc2_result_scheduler;
    localparam int NC = 10, IL = 84, ML = 2, PER = IL + ML + 1;
    localparam int LAT = NC * PER + 2;
`ifdef FC2_BIAS_EN
    localparam logic [3:0] EXP = 4'd9;
`else
    localparam logic [3:0] EXP = 4'd2;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, result_ready = 1'b0, am_force = 1'b0;
    logic busy, mac_en, mac_clr, score_en, argmax_valid, result_valid;
    logic [6:0] feat_addr;
    logic [9:0] wgt_addr;
    logic signed [31:0] mac_acc, score;
    logic [3:0] argmax_class, result;
    logic signed [31:0] sums [NC];
    logic signed [31:0] bias [NC];
    int vec = 0, err = 0, cyc = 0, wmax = 0, s0 = 0;
    int clr_q[$], sen_c[$];
    logic signed [31:0] sen_v[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef FC2_BIAS_EN
    logic [3:0] bias_addr;
    logic signed [31:0] bias_data;
    always @(posedge clk) bias_data <= (int'(bias_addr) < NC) ? bias[bias_addr] : 32'sd0;
`endif

    fc2_result_scheduler #(.NUM_CLASSES(NC), .IN_LEN(IL), .ADDR_W(7), .WADDR_W(10), .MAC_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .o_busy(busy),
        .o_feat_addr(feat_addr), .o_wgt_addr(wgt_addr), .o_mac_en(mac_en), .o_mac_clr(mac_clr),
        .i_mac_acc(mac_acc), .o_score(score), .o_score_en(score_en),
`ifdef FC2_BIAS_EN
        .o_bias_addr(bias_addr), .i_bias_data(bias_data),
`endif
        .i_argmax_valid(argmax_valid), .i_argmax_class(argmax_class),
        .o_result(result), .o_result_valid(result_valid), .i_result_ready(result_ready));

    // MAC: products sum to sums[class] only if every feature index 0..IL-1 is visited with the right weight block
    logic signed [31:0] prod, acc1, acc2;
    int widx;
    always_comb begin
        widx = int'(wgt_addr) / IL;
        prod = 32'sd1;
        if (feat_addr == 7'd0) prod = (widx < NC) ? sums[widx] - 32'sd83 : 32'sd0;
    end
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc1 <= 0;
            acc2 <= 0;
        end else begin
            if (mac_en) acc1 <= mac_clr ? prod : acc1 + prod;
            acc2 <= acc1;
        end
    assign mac_acc = acc2;

    // argmax: first maximum wins, valid one cycle after the tenth score
    logic signed [31:0] am_best;
    logic [3:0] am_cnt, am_idx, am_class;
    logic am_valid;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            am_best <= 0; am_cnt <= 0; am_idx <= 0; am_class <= 0; am_valid <= 0;
        end else begin
            am_valid <= 1'b0;
            if (score_en) begin
                if (am_cnt == 0 || score > am_best) begin
                    am_best <= score;
                    am_idx  <= am_cnt;
                end
                if (am_cnt == 4'(NC - 1)) begin
                    am_valid <= 1'b1;
                    am_class <= (score > am_best) ? am_cnt : am_idx;
                    am_cnt   <= 0;
                end else am_cnt <= am_cnt + 1'b1;
            end
        end
    assign argmax_valid = am_valid | am_force;
    assign argmax_class = am_force ? 4'd7 : am_class;

    always @(negedge clk) begin
        if (mac_clr) clr_q.push_back(cyc);
        if (score_en) begin
            sen_c.push_back(cyc);
            sen_v.push_back(score);
        end
        if (mac_en && int'(wgt_addr) > wmax) wmax = int'(wgt_addr);
    end

    function automatic bit all_zero();
        return {busy, mac_en, mac_clr, score_en, result_valid} == 5'b0 && feat_addr == 0 &&
               wgt_addr == 0 && score == 0 && result == 0;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        clr_q.delete(); sen_c.delete(); sen_v.delete(); wmax = 0;
        start = 1'b1;
        s0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(output int rel, output int busy_low);
        int n = 0;
        busy_low = 0;
        while (!result_valid && n < 3000) begin
            am_force = (cyc - s0 == 199);
            @(negedge clk);
            n++;
            if (!busy) busy_low++;
        end
        am_force = 1'b0;
        rel = result_valid ? cyc - s0 : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec++;
            if (!all_zero()) begin
                err++;
                $display("FAIL reset_idle cyc%0d: busy=%b mac_en=%b score_en=%b rv=%b wgt=%0d, required all 0",
                         i, busy, mac_en, score_en, result_valid, wgt_addr);
            end
        end
    endtask

    task automatic test_inference();
        int rel, bl;
        pulse_start();
        vec++;
        if (busy !== 1'b1) begin err++; $display("FAIL busy_rise: got %b, required 1", busy); end
        wait_result(rel, bl);
        vec++;
        if (rel != LAT) begin err++; $display("FAIL latency: got %0d, required %0d", rel, LAT); end
        vec++;
        if (bl != 0) begin err++; $display("FAIL busy_held: low for %0d cycles, required 0", bl); end
        vec++;
        if (sen_c.size() != NC) begin err++; $display("FAIL score_count: got %0d, required %0d", sen_c.size(), NC); end
        for (int k = 0; k < NC && k < sen_c.size(); k++) begin
            vec++;
            if (sen_c[k] - s0 != PER * (k + 1)) begin
                err++; $display("FAIL score_time[%0d]: got %0d, required %0d", k, sen_c[k] - s0, PER * (k + 1));
            end
            vec++;
            if (sen_v[k] !== sums[k] + bias[k]) begin
                err++; $display("FAIL score_val[%0d]: got %0d, required %0d", k, sen_v[k], sums[k] + bias[k]);
            end
        end
        vec++;
        if (clr_q.size() != NC) begin err++; $display("FAIL clr_count: got %0d, required %0d", clr_q.size(), NC); end
        for (int k = 0; k < 3 && k < clr_q.size(); k++) begin
            vec++;
            if (clr_q[k] - s0 != 1 + PER * k) begin
                err++; $display("FAIL clr_time[%0d]: got %0d, required %0d", k, clr_q[k] - s0, 1 + PER * k);
            end
        end
        vec++;
        if (wmax != NC * IL - 1) begin err++; $display("FAIL wgt_last: got %0d, required %0d", wmax, NC * IL - 1); end
        vec++;
        if (result !== EXP) begin err++; $display("FAIL result: got %0d, required %0d", result, EXP); end
    endtask

    task automatic test_hold();
        result_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vec++;
            if (result_valid !== 1'b1 || result !== EXP || busy !== 1'b1) begin
                err++; $display("FAIL hold cyc%0d: valid=%b result=%0d busy=%b, required 1/%0d/1", i, result_valid, result, busy, EXP);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        vec++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            err++; $display("FAIL handshake: valid=%b busy=%b, required 0/0", result_valid, busy);
        end
    endtask

    task automatic test_start_ignored_reset();
        int rel, bl;
        pulse_start();
        while (cyc - s0 < 4 * PER + 20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vec++;
        if (busy !== 1'b1) begin err++; $display("FAIL start_busy: busy=%b, required 1", busy); end
        while (cyc - s0 < 6 * PER + 30) @(negedge clk);
        vec++;
        if (clr_q.size() != 7) begin err++; $display("FAIL restart_clr_count: got %0d, required 7", clr_q.size()); end
        else for (int k = 4; k < 7; k++) begin
            vec++;
            if (clr_q[k] - s0 != 1 + PER * k) begin
                err++; $display("FAIL restart_clr[%0d]: got %0d, required %0d", k, clr_q[k] - s0, 1 + PER * k);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (!all_zero()) begin
            err++; $display("FAIL async_reset: busy=%b mac_en=%b feat=%0d wgt=%0d score=%0d, required all 0",
                            busy, mac_en, feat_addr, wgt_addr, score);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        result_ready = 1'b1;
        pulse_start();
        wait_result(rel, bl);
        vec++;
        if (rel != LAT || result !== EXP) begin
            err++; $display("FAIL fresh_run: latency=%0d result=%0d, required %0d/%0d", rel, result, LAT, EXP);
        end
        vec++;
        if (sen_c.size() != NC) begin err++; $display("FAIL fresh_scores: got %0d, required %0d", sen_c.size(), NC); end
        @(negedge clk);
        result_ready = 1'b0;
        vec++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            err++; $display("FAIL early_ready: valid=%b busy=%b, required 0/0", result_valid, busy);
        end
    endtask

    initial begin
        sums = '{32'sd5, -32'sd3, 32'sd40, 32'sd40, 32'sd2, 32'sd0, -32'sd100, 32'sd7, 32'sd39, 32'sd1};
        bias = '{default: 32'sd0};
`ifdef FC2_BIAS_EN
        sums[0] = 32'sh7FFFFFFF;
        bias[0] = 32'sd1;
        bias[9] = 32'sd50;
`endif
        test_reset();
        test_inference();
        test_hold();
        test_start_ignored_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fc2_result_scheduler.md
Name: fc2_result_scheduler

Overview:
- Sequences the FC2 output layer. For each of NUM_CLASSES classes it streams IN_LEN feature/weight address pairs into an external MAC.
- It waits out the MAC pipeline, then hands each 32-bit class score to the argmax stage with a one-cycle enable.
- It collects the 4-bit argmax class and offers it to the AXI/PS side through a valid/ready handshake.
- It sits between the FC2 feature buffer, the weight ROM, the MAC and the final-result stage.

Parameters:
- NUM_CLASSES, 10: number of output classes / scores issued per inference.
- IN_LEN, 84: FC2 input vector length (MAC cycles per class).
- ADDR_W, 7: feature address width; must satisfy 2^ADDR_W >= IN_LEN.
- WADDR_W, 10: weight address width; must satisfy 2^WADDR_W >= NUM_CLASSES*IN_LEN.
- MAC_LAT, 2: cycles from the last mac_en until mac_acc holds the final sum (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin an inference
- busy  out  1  high from start acceptance until the result handshake completes
- feat_addr  out  ADDR_W  feature buffer read address
- wgt_addr  out  WADDR_W  weight ROM read address
- mac_en  out  1  MAC accumulate enable
- mac_clr  out  1  high with the first mac_en of each class; MAC loads the product instead of accumulating
- mac_acc  in  32 signed  MAC accumulator output
- score  out  32 signed  class score to the argmax stage
- score_en  out  1  one-cycle enable, drives the argmax enable
- argmax_valid  in  1  argmax result-valid flag
- argmax_class  in  4  argmax class index
- result  out  4  final class
- result_valid  out  1  result handshake valid
- result_ready  in  1  result handshake ready

Behaviour:
- Reset values: all outputs are 0. FSM is in IDLE; class counter, index counter and drain counter are 0.
- FSM states: IDLE, RUN, DRAIN, EMIT, WAIT_AM, HOLD.
- IDLE:
  - start=1 moves to RUN.
  - busy goes high the next cycle.
  - Class counter, index counter and wgt_addr are cleared to 0.
- RUN:
  - mac_en=1 every cycle; feat_addr = index; wgt_addr = running counter.
  - wgt_addr increments on every mac_en and is never computed with a multiplier.
  - mac_clr=1 only when index==0.
  - After the cycle with index==IN_LEN-1: index wraps to 0 and the FSM goes to DRAIN.
- DRAIN:
  - mac_en=0.
  - Counts MAC_LAT cycles, then goes to EMIT.
- EMIT:
  - Lasts one cycle; score_en=1 and score = mac_acc, registered on entry.
  - If class==NUM_CLASSES-1, go to WAIT_AM.
  - Otherwise class increments and the FSM returns to RUN.
- WAIT_AM:
  - On argmax_valid=1, latch argmax_class into result, set result_valid=1 and go to HOLD.
- HOLD:
  - result_valid stays high and result stays stable until result_ready=1.
  - On that cycle the transfer completes: result_valid=0 next cycle, busy=0, FSM returns to IDLE.
  - result_ready may be high before valid; the transfer then completes in the first valid cycle.
- Timing per class: IN_LEN + MAC_LAT + 1 cycles. Total time start->result_valid = NUM_CLASSES*(IN_LEN+MAC_LAT+1) + argmax latency + 1.
- score_en pulses are spaced exactly IN_LEN+MAC_LAT+1 cycles apart; never back-to-back.
- start while busy=1 is ignored; no queueing.
- argmax_valid outside WAIT_AM is ignored.
- Reset asserted mid-inference: immediately returns to reset values. The partially fed argmax stage is reset by the same rst_n.
- score is held between pulses; downstream qualifies it with score_en only.

Optional Feature:
FC2_BIAS_EN
- Defined:
  - Adds ports bias_addr out CLS_W=4 (equals the class counter, valid from DRAIN through EMIT) and bias_data in 32 signed (synchronous ROM, 1-cycle read).
  - EMIT score = mac_acc + bias_data, with 32-bit two's-complement wraparound.
  - DRAIN must last at least 1 cycle; MAC_LAT>=1 guarantees this.
- Undefined: no bias ports; score = mac_acc.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, no mac_en, no score_en.
- start=1 with IN_LEN=84, MAC_LAT=2 -> mac_clr high on cycles 1, 88, 175, ...
  - wgt_addr ends at 839.
  - Exactly 10 score_en pulses 87 cycles apart.
  - busy high throughout.
- MAC model returning per-class sums {5,-3,40,40,2,0,-100,7,39,1}, cascaded with argmax stage -> result=2 and result_valid asserted.
- result_ready held low 15 cycles -> result_valid and result=2 stay stable; ready=1 -> valid drops next cycle and busy=0.
- start pulsed during RUN at class 4, and rst_n pulsed low during class 6 -> the start has no effect; after reset all outputs are 0 and a fresh start completes normally.
- FC2_BIAS_EN with mac_acc=0x7FFFFFFF and bias=1 -> score=0x80000000. With bias {0,...,+50 on class 9} -> result=9.
